// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error strobe
module uart_rx #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [12:0] HALF_TERM = 13'(BAUD_DIV / 2 - 1);
   localparam logic [12:0] BIT_TERM  = 13'(BAUD_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        rx_s_q, rx_s_d;
   logic        rx_d_q, rx_d_d;
   logic        fall_q, fall_d;
   logic [12:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        stop_hit_q, stop_hit_d;
   logic        stop_bit_q, stop_bit_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        valid_q, valid_d;
   logic        frame_err_q, frame_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_d_q      <= 1'b1;
         fall_q      <= 1'b0;
         baud_cnt_q  <= 13'd0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         stop_hit_q  <= 1'b0;
         stop_bit_q  <= 1'b0;
         data_out_q  <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rx_s_q      <= rx_s_d;
         rx_d_q      <= rx_d_d;
         fall_q      <= fall_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         stop_hit_q  <= stop_hit_d;
         stop_bit_q  <= stop_bit_d;
         data_out_q  <= data_out_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      sync1_d     = rx;
      rx_s_d      = sync1_q;
      rx_d_d      = rx_s_q;
      fall_d      = rx_d_q & ~rx_s_q;
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      stop_hit_d  = 1'b0;
      stop_bit_d  = stop_bit_q;
      data_out_d  = data_out_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            baud_cnt_d = 13'd0;
            bit_idx_d  = 3'd0;
            if (fall_q) begin
               state_d = START;
            end
         end
         START: begin
            if (baud_cnt_q == HALF_TERM) begin
               baud_cnt_d = 13'd0;
               // A line back high at mid-start was only a glitch.
               state_d    = rx_s_q ? IDLE : DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 13'd1;
            end
         end
         DATA: begin
            if (baud_cnt_q == BIT_TERM) begin
               baud_cnt_d = 13'd0;
               shift_d    = {rx_s_q, shift_q[7:1]};
               bit_idx_d  = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 13'd1;
            end
         end
         STOP: begin
            // Stop sample is held one cycle so the strobe lands the cycle after it.
            if (stop_hit_q) begin
               state_d    = IDLE;
               baud_cnt_d = 13'd0;
               if (stop_bit_q) begin
                  data_out_d = shift_q;
                  valid_d    = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else if (baud_cnt_q == BIT_TERM) begin
               baud_cnt_d = 13'd0;
               stop_hit_d = 1'b1;
               stop_bit_d = rx_s_q;
            end else begin
               baud_cnt_d = baud_cnt_q + 13'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data_out  = data_out_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized frame bench for uart_rx with an event-queue reference model
module tb_uart_rx;

   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(.BAUD_DIV(BD)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .data_out(data_out),
      .valid(valid),
      .frame_err(frame_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [7:0] data;
      bit         err;
      int         t0;
   } exp_t;

   exp_t       expq[$];
   int         tests = 0;
   int         fails = 0;
   logic [7:0] model_data = 8'h00;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         busy_run = 0;
   int         last_busy = 0;
   int         last_valid_cyc = 0;
   int         prev_valid_cyc = 0;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d at cycle %0d", name, act, lo, hi, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Ideal frame: 16-clk bits; the expected strobe is queued when the start edge is driven.
   task automatic send(input logic [7:0] b, input bit stop);
      exp_t e;
      e.data = b;
      e.err  = !stop;
      e.t0   = cyc;
      expq.push_back(e);
      rx = 1'b0;
      tick(BD);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BD);
      end
      rx = stop;
      tick(BD);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      expq.delete();
      model_data = 8'h00;
      busy_run = 0;
      #1;
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid", valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      tick(3);
      rst = 1'b0;
   endtask

   // Compare process: strobes must match queued frames in order, kind and latency window.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            check("strobe_exclusive", int'(valid && frame_err), 0);
            if (valid || frame_err) begin
               if (expq.size() == 0) begin
                  check("unexpected_strobe", int'(frame_err), 2);
               end else begin
                  e = expq.pop_front();
                  check("strobe_kind_err", int'(frame_err), int'(e.err));
                  check_rng("strobe_latency", cyc - e.t0, 156, 157);
                  if (!e.err) model_data = e.data;
               end
               check("busy_low_on_strobe", busy, 0);
               if (valid) begin
                  valid_cnt++;
                  prev_valid_cyc = last_valid_cyc;
                  last_valid_cyc = cyc;
               end
               if (frame_err) err_cnt++;
            end else if (expq.size() > 0 && (cyc - expq[0].t0) > 160) begin
               check("strobe_timeout", 0, 1);
               void'(expq.pop_front());
            end
            check("data_out", data_out, model_data);
            if (busy) begin
               busy_run++;
            end else begin
               if (busy_run > 0) last_busy = busy_run;
               busy_run = 0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, e0;
      logic [7:0] b;
      bit stop;
      tick(3);
      check("init_data_out", data_out, 8'h00);
      check("init_valid", valid, 0);
      check("init_busy", busy, 0);
      rst = 1'b0;
      tick(10);

      // Single frame
      v0 = valid_cnt; e0 = err_cnt;
      send(8'h55, 1'b1);
      tick(10);
      check("single_data", data_out, 8'h55);
      check("single_valid_cnt", valid_cnt - v0, 1);
      check("single_err_cnt", err_cnt - e0, 0);
      check("single_busy_len", last_busy, 8 + 9 * BD + 1);

      // Back-to-back, no idle gap
      v0 = valid_cnt;
      send(8'hA3, 1'b1);
      send(8'h0F, 1'b1);
      tick(10);
      check("b2b_valid_cnt", valid_cnt - v0, 2);
      check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);
      check("b2b_data", data_out, 8'h0F);

      // Glitch rejection
      v0 = valid_cnt; e0 = err_cnt; last_busy = 0;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(40);
      check("glitch_valid_cnt", valid_cnt - v0, 0);
      check("glitch_err_cnt", err_cnt - e0, 0);
      check_rng("glitch_busy_len", last_busy, 1, 9);

      // Framing error after a good byte
      v0 = valid_cnt; e0 = err_cnt;
      send(8'h3C, 1'b1);
      send(8'h96, 1'b0);
      rx = 1'b1;
      tick(20);
      check("ferr_valid_cnt", valid_cnt - v0, 1);
      check("ferr_err_cnt", err_cnt - e0, 1);
      check("ferr_data_held", data_out, 8'h3C);

      // Break: line held low
      e0 = err_cnt;
      begin
         exp_t e;
         e.data = 8'h00; e.err = 1'b1; e.t0 = cyc;
         expq.push_back(e);
      end
      rx = 1'b0;
      tick(400);
      rx = 1'b1;
      check("break_err_cnt", err_cnt - e0, 1);
      tick(20);
      send(8'h81, 1'b1);
      tick(10);
      check("break_recover_data", data_out, 8'h81);

      // Reset during bit 4 of 0xFF
      v0 = valid_cnt;
      rx = 1'b0;
      tick(BD);
      rx = 1'b1;
      tick(4 * BD + 8);
      check("midframe_busy", busy, 1);
      do_reset();
      tick(200);
      check("abort_no_pulse", valid_cnt - v0, 0);
      send(8'h12, 1'b1);
      tick(10);
      check("post_reset_data", data_out, 8'h12);

      // Randomized frames, gaps and stop bits
      for (int n = 0; n < 12; n++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         send(b, stop);
         rx = 1'b1;
         tick(stop ? int'($urandom_range(0, 12)) : 4 + int'($urandom_range(0, 8)));
      end
      rx = 1'b1;
      tick(50);
      check("queue_drained", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
